// File: rtl/snn_adder_pkg.sv
// Shared definitions for the SNN adder: packet field layout, type codes,
// NoC addresses and the adder FSM state encoding.
package snn_adder_pkg;

    localparam int PKT_W     = 34;
    localparam int ADDR_W    = 4;
    localparam int TYPE_W    = 2;
    localparam int PAYLOAD_W = 24;
    localparam int POT_W     = 8;
    localparam int ACC_W     = 10;

    localparam int SRC_LSB  = 30;
    localparam int DST_LSB  = 26;
    localparam int TYPE_LSB = 24;

    localparam logic [TYPE_W-1:0] TYPE_INPUT  = 2'b00;
    localparam logic [TYPE_W-1:0] TYPE_KERNEL = 2'b01;
    localparam logic [TYPE_W-1:0] TYPE_MEM    = 2'b10;
    localparam logic [TYPE_W-1:0] TYPE_OUT    = 2'b11;

    localparam logic [3:0] DONE_CODE = 4'b1111;

    localparam logic [ADDR_W-1:0]   ADDR_WRAPPER = 4'b0000;
    localparam logic [ADDR_W-1:0]   ADDR_ADDER   = 4'b0001;
    // Packed as {PE3, PE2, PE1}; PE1 occupies the low nibble.
    localparam logic [3*ADDR_W-1:0] ADDR_PES     = {4'b1010, 4'b0110, 4'b0010};

    typedef enum logic [2:0] {
        COLLECT,
        CALC,
        SEND_SPK,
        SEND_MEM,
        SEND_DN
    } state_t;

    function automatic logic [PKT_W-1:0] make_pkt(
        input logic [ADDR_W-1:0]    src,
        input logic [ADDR_W-1:0]    dst,
        input logic [TYPE_W-1:0]    kind,
        input logic [PAYLOAD_W-1:0] payload
    );
        return {src, dst, kind, payload};
    endfunction

endpackage

// File: rtl/snn_pkt_fmt.sv
// Combinational packet decode for ingress and packet build for the three
// egress packet kinds (spike, membrane potential, row DONE).
module snn_pkt_fmt
    import snn_adder_pkg::*;
#(
    parameter logic [3:0]  ADDR         = ADDR_ADDER,
    parameter logic [3:0]  WRAPPER_ADDR = ADDR_WRAPPER,
    parameter logic [11:0] PE_ADDRS     = ADDR_PES,
    parameter logic [1:0]  COL          = 2'd0
) (
    input  logic [33:0] pkt,
    input  logic [1:0]  row,
    input  logic [7:0]  pot,
    output logic        for_me,
    output logic [2:0]  pe_hit,
    output logic        mem_hit,
    output logic [7:0]  value,
    output logic [33:0] spk_pkt,
    output logic [33:0] mem_pkt,
    output logic [33:0] dn_pkt
);

    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [TYPE_W-1:0] kind;
    logic              unused_payload_hi;

    assign src   = pkt[SRC_LSB +: ADDR_W];
    assign dst   = pkt[DST_LSB +: ADDR_W];
    assign kind  = pkt[TYPE_LSB +: TYPE_W];
    assign value = pkt[POT_W-1:0];

    // Only the low byte of the payload carries data on ingress.
    assign unused_payload_hi = ^pkt[PAYLOAD_W-1:POT_W];

    assign for_me  = (dst == ADDR);
    assign mem_hit = (kind == TYPE_MEM) && (src == WRAPPER_ADDR);

    always_comb begin
        pe_hit = '0;
        for (int i = 0; i < 3; i++) begin
            pe_hit[i] = (kind == TYPE_INPUT) && (src == PE_ADDRS[ADDR_W*i +: ADDR_W]);
        end
    end

    assign spk_pkt = make_pkt(ADDR, WRAPPER_ADDR, TYPE_OUT, {20'b0, row, COL});
    assign mem_pkt = make_pkt(ADDR, WRAPPER_ADDR, TYPE_MEM, {16'b0, pot});
    assign dn_pkt  = make_pkt(ADDR, WRAPPER_ADDR, TYPE_OUT, {20'b0, DONE_CODE});

endmodule

// File: rtl/snn_adder.sv
// Output-map adder of the SNN accelerator: sums three PE partial sums plus
// the stored membrane potential, thresholds it, and reports spike/potential.
module snn_adder
    import snn_adder_pkg::*;
#(
    parameter logic [3:0]  ADDR         = ADDR_ADDER,
    parameter logic [3:0]  WRAPPER_ADDR = ADDR_WRAPPER,
    parameter logic [11:0] PE_ADDRS     = ADDR_PES,
    parameter logic [1:0]  COL          = 2'd0,
    parameter logic [7:0]  THRESH       = 8'd64,
    parameter int          NUM_ROWS     = 3,
    parameter bit          SEND_DONE    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PKT_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PKT_W-1:0]  out_data,
    output logic              err
);

    localparam logic [1:0] ROW_LAST = 2'(NUM_ROWS - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [2:0]       got;
    logic             mem_got;
    logic [1:0]       row;
    logic             first_ts;
    logic [POT_W-1:0] newpot;

    logic             for_me;
    logic [2:0]       pe_hit;
    logic             mem_hit;
    logic [POT_W-1:0] value;
    logic [PKT_W-1:0] spk_pkt;
    logic [PKT_W-1:0] mem_pkt;
    logic [PKT_W-1:0] dn_pkt;

    logic             accept;
    logic             psum_ok;
    logic             mem_ok;
    logic             calc_ready;
    logic             row_done;
    logic [POT_W-1:0] sum;
    logic [POT_W-1:0] calc_pot;
    logic             fire;
    logic [POT_W-1:0] pot_sel;

    // The potential is still combinational during CALC and registered after it.
    assign pot_sel = (state == CALC) ? calc_pot : newpot;

    snn_pkt_fmt #(
        .ADDR         (ADDR),
        .WRAPPER_ADDR (WRAPPER_ADDR),
        .PE_ADDRS     (PE_ADDRS),
        .COL          (COL)
    ) u_fmt (
        .pkt     (in_data),
        .row     (row),
        .pot     (pot_sel),
        .for_me  (for_me),
        .pe_hit  (pe_hit),
        .mem_hit (mem_hit),
        .value   (value),
        .spk_pkt (spk_pkt),
        .mem_pkt (mem_pkt),
        .dn_pkt  (dn_pkt)
    );

    assign in_ready   = (state == COLLECT);
    assign accept     = in_valid && in_ready;
    assign psum_ok    = for_me && ((pe_hit & ~got) != 3'b000);
    assign mem_ok     = for_me && mem_hit && !first_ts && !mem_got;
    assign calc_ready = (&got) && (first_ts || mem_got);

    assign sum      = (acc > 10'd255) ? 8'hFF : acc[POT_W-1:0];
    assign fire     = (sum >= THRESH);
    assign calc_pot = fire ? (sum - THRESH) : sum;

    assign row_done = out_valid && out_ready &&
                      (((state == SEND_MEM) && !SEND_DONE) || (state == SEND_DN));

    // Any packet that is not a fresh PE psum or an expected potential is
    // swallowed and flagged, so a misbehaving sender can never stall the NoC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            acc       <= '0;
            got       <= '0;
            mem_got   <= 1'b0;
            row       <= '0;
            first_ts  <= 1'b1;
            newpot    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        if (psum_ok) begin
                            acc <= acc + ACC_W'(value);
                            got <= got | pe_hit;
                        end else if (mem_ok) begin
                            acc     <= acc + ACC_W'(value);
                            mem_got <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (calc_ready) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    newpot    <= calc_pot;
                    out_valid <= 1'b1;
                    if (fire) begin
                        out_data <= spk_pkt;
                        state    <= SEND_SPK;
                    end else begin
                        out_data <= mem_pkt;
                        state    <= SEND_MEM;
                    end
                end
                SEND_SPK: begin
                    if (out_ready) begin
                        out_data <= mem_pkt;
                        state    <= SEND_MEM;
                    end
                end
                SEND_MEM: begin
                    if (out_ready && SEND_DONE) begin
                        out_data <= dn_pkt;
                        state    <= SEND_DN;
                    end
                end
                SEND_DN: begin
                end
                default: begin
                    state <= COLLECT;
                end
            endcase

            // Last packet of the row accepted: rearm for the next row.
            if (row_done) begin
                state     <= COLLECT;
                out_valid <= 1'b0;
                out_data  <= '0;
                acc       <= '0;
                got       <= '0;
                mem_got   <= 1'b0;
                if (row == ROW_LAST) begin
                    row      <= '0;
                    first_ts <= 1'b0;
                end else begin
                    row <= row + 2'd1;
                end
            end
        end
    end

endmodule
